bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Three-requester arbiter sharing one 8-bit memory port with MEM_WAIT wait states.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority 0 > 1 > 2.
module bus_arbiter #(
    parameter int MEM_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [2:0]  req_we,
    input  logic [23:0] req_addr,
    input  logic [23:0] req_wdata,
    output logic [2:0]  gnt,
    output logic [2:0]  ack,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        mem_en,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    // Handshake: req is a level sampled only in IDLE. gnt is held for the whole transaction,
    // and ack pulses for one cycle inside it. A granted transaction always completes.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    state_t     r_state;
    logic [2:0] r_cnt;
    logic       r_we;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [2:0] r_gnt;
    logic [2:0] r_ack;
    logic [7:0] r_rdata;
    logic       r_busy;
    logic       r_mem_en;
    logic       r_mem_we;
    logic [7:0] r_mem_addr;
    logic [7:0] r_mem_wdata;

    logic       w_any;
    logic [1:0] w_win;

    function automatic logic [7:0] lane(input logic [23:0] v, input logic [1:0] i);
        case (i)
            2'd0:    lane = v[7:0];
            2'd1:    lane = v[15:8];
            default: lane = v[23:16];
        endcase
    endfunction

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] r_ptr;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        next_idx = (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Search starts one past the last winner and wraps modulo 3.
    always_comb begin
        logic [1:0] v_idx;
        w_any = 1'b0;
        w_win = 2'd0;
        v_idx = r_ptr;
        for (int k = 0; k < 3; k++) begin
            v_idx = next_idx(v_idx);
            if (!w_any && req[v_idx]) begin
                w_any = 1'b1;
                w_win = v_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 2'd2;
        end else if (r_state == IDLE && w_any) begin
            r_ptr <= w_win;
        end
    end
`else
    always_comb begin
        w_any = |req;
        if (req[0]) begin
            w_win = 2'd0;
        end else if (req[1]) begin
            w_win = 2'd1;
        end else begin
            w_win = 2'd2;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 3'd0;
            r_we        <= 1'b0;
            r_addr      <= 8'd0;
            r_wdata     <= 8'd0;
            r_gnt       <= 3'd0;
            r_ack       <= 3'd0;
            r_rdata     <= 8'd0;
            r_busy      <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 8'd0;
            r_mem_wdata <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_we    <= req_we[w_win];
                        r_addr  <= lane(req_addr, w_win);
                        r_wdata <= lane(req_wdata, w_win);
                        r_gnt   <= 3'b001 << w_win;
                        r_cnt   <= 3'd0;
                        r_busy  <= 1'b1;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // The first ACCESS cycle is a setup cycle; the memory port opens after it.
                    if (!r_mem_en) begin
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= r_we;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= r_wdata;
                    end else if (r_cnt == WAIT_LAST) begin
                        if (!r_mem_we) begin
                            r_rdata <= mem_rdata;
                        end
                        r_mem_en    <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= 8'd0;
                        r_mem_wdata <= 8'd0;
                        r_ack       <= r_gnt;
                        r_state     <= ACK;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                ACK: begin
                    r_ack   <= 3'd0;
                    r_gnt   <= 3'd0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign ack       = r_ack;
    assign rdata     = r_rdata;
    assign busy      = r_busy;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
